// File: rtl/hyperbus_cfg_seq_if.sv
// Register-bus bundle between the config sequencer and the controller.
// master: sequencer (drives request); slave: controller (answers).
interface hyperbus_cfg_seq_if #(
  parameter int unsigned RegAw = 32,
  parameter int unsigned RegDw = 32
);
  logic [RegAw-1:0]   reg_addr;
  logic               reg_write;
  logic [RegDw-1:0]   reg_wdata;
  logic [RegDw/8-1:0] reg_wstrb;
  logic               reg_valid;
  logic [RegDw-1:0]   reg_rdata;
  logic               reg_error;
  logic               reg_ready;

  modport master (
    output reg_addr, reg_write, reg_wdata,
    output reg_wstrb, reg_valid,
    input  reg_rdata, reg_error, reg_ready
  );

  modport slave (
    input  reg_addr, reg_write, reg_wdata,
    input  reg_wstrb, reg_valid,
    output reg_rdata, reg_error, reg_ready
  );
endinterface

// File: rtl/hyperbus_cfg_seq.sv
// Issues a fixed list of register writes (optional readback) after reset
// or start_i, then opens axi_gate_o. Ports: clk_i/rst_ni, start_i,
// reg_bus (master), busy_o/done_o/err_o/err_idx_o/axi_gate_o status.
module hyperbus_cfg_seq #(
  parameter int unsigned RegAw      = 32,
  parameter int unsigned RegDw      = 32,
  parameter int unsigned NumEntries = 8,
  parameter logic [NumEntries-1:0][RegAw-1:0] CfgAddr = '0,
  parameter logic [NumEntries-1:0][RegDw-1:0] CfgData = '0,
  parameter int unsigned Verify     = 0,
  parameter logic [RegDw-1:0] VerifyMask = '1,
  parameter int unsigned AutoStart  = 1,
  localparam int unsigned IdxW =
    (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  hyperbus_cfg_seq_if.master reg_bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [IdxW-1:0] err_idx_o,
  output logic            axi_gate_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IdxW-1:0] LastIdx =
    IdxW'(NumEntries - 1);

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  eidx_q, eidx_d;
  logic             armed_q, armed_d;
  logic             kick_q, kick_d;
  logic             valid_q, valid_d;
  logic             write_q, write_d;
  logic [RegAw-1:0] addr_q, addr_d;
  logic [RegDw-1:0] wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             gate_q, gate_d;
  logic             hs, last, mism;

  function automatic logic [RegAw-1:0] cfg_addr(
    input logic [IdxW-1:0] i
  );
    cfg_addr = '0;
    for (int n = 0; n < int'(NumEntries); n++)
      if (i == IdxW'(n)) cfg_addr = CfgAddr[n];
  endfunction

  function automatic logic [RegDw-1:0] cfg_data(
    input logic [IdxW-1:0] i
  );
    cfg_data = '0;
    for (int n = 0; n < int'(NumEntries); n++)
      if (i == IdxW'(n)) cfg_data = CfgData[n];
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    done_d  = done_q;
    err_d   = err_q;
    armed_d = 1'b0;
    // armed_q is high only in the first cycle after reset release;
    // kick_q turns that into a start sampled one edge later.
    kick_d  = armed_q & (AutoStart != 0);
    hs      = valid_q & reg_bus.reg_ready;
    last    = (idx_q == LastIdx);
    mism    = |((reg_bus.reg_rdata ^ cfg_data(idx_q))
                & VerifyMask);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i | kick_q) begin
          state_d = S_WR;
          idx_d   = '0;
          eidx_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_WR: begin
        if (hs) begin
          if (reg_bus.reg_error) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            eidx_d  = idx_q;
          end else if (Verify != 0) begin
            state_d = S_RD;
          end else if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (hs) begin
          if (reg_bus.reg_error | mism) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            eidx_d  = idx_q;
          end else if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WR;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
    endcase
    // Request fields are registered from the next state so the
    // outputs never depend combinationally on reg_bus inputs.
    valid_d = (state_d == S_WR) || (state_d == S_RD);
    write_d = (state_d == S_WR);
    addr_d  = valid_d ? cfg_addr(idx_d) : addr_q;
    wdata_d = valid_d ? cfg_data(idx_d) : wdata_q;
    gate_d  = done_d & ~err_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      eidx_q  <= '0;
      armed_q <= 1'b1;
      kick_q  <= 1'b0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      armed_q <= armed_d;
      kick_q  <= kick_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gate_q  <= gate_d;
    end
  end

  assign reg_bus.reg_addr  = addr_q;
  assign reg_bus.reg_write = write_q;
  assign reg_bus.reg_wdata = wdata_q;
  assign reg_bus.reg_wstrb = '1;
  assign reg_bus.reg_valid = valid_q;
  assign busy_o     = valid_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_idx_o  = eidx_q;
  assign axi_gate_o = gate_q;

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Bench for hyperbus_cfg_seq: three configurations driven by a
// memory-backed slave with fault injection and a transcript model.
module tb_hyperbus_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] st, rdy, rerr, vld, wr, busy, done, err, gate;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdat [3];
  logic [1:0]  eidx [3];
  logic [1:0]  eidx0, eidx1;
  logic [0:0]  eidx2;

  int checks = 0;
  int errors = 0;

  hyperbus_cfg_seq_if bus_a ();
  hyperbus_cfg_seq_if bus_b ();
  hyperbus_cfg_seq_if bus_c ();

  hyperbus_cfg_seq #(
    .NumEntries(3),
    .CfgAddr({32'h8, 32'h4, 32'h0}),
    .CfgData({32'h33, 32'h22, 32'h11}),
    .Verify(0), .AutoStart(1)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]),
    .reg_bus(bus_a), .busy_o(busy[0]), .done_o(done[0]),
    .err_o(err[0]), .err_idx_o(eidx0), .axi_gate_o(gate[0])
  );

  hyperbus_cfg_seq #(
    .NumEntries(3),
    .CfgAddr({32'h8, 32'h4, 32'h0}),
    .CfgData({32'h33, 32'h22, 32'h11}),
    .Verify(1), .VerifyMask(32'hFF), .AutoStart(1)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]),
    .reg_bus(bus_b), .busy_o(busy[1]), .done_o(done[1]),
    .err_o(err[1]), .err_idx_o(eidx1), .axi_gate_o(gate[1])
  );

  hyperbus_cfg_seq #(
    .NumEntries(1),
    .CfgAddr(32'h10),
    .CfgData(32'hCAFE_0001),
    .Verify(1), .AutoStart(0)
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]),
    .reg_bus(bus_c), .busy_o(busy[2]), .done_o(done[2]),
    .err_o(err[2]), .err_idx_o(eidx2), .axi_gate_o(gate[2])
  );

  assign eidx[0] = eidx0;
  assign eidx[1] = eidx1;
  assign eidx[2] = {1'b0, eidx2};
  assign vld = {bus_c.reg_valid, bus_b.reg_valid, bus_a.reg_valid};
  assign wr  = {bus_c.reg_write, bus_b.reg_write, bus_a.reg_write};
  assign addr[0]  = bus_a.reg_addr;
  assign addr[1]  = bus_b.reg_addr;
  assign addr[2]  = bus_c.reg_addr;
  assign wdata[0] = bus_a.reg_wdata;
  assign wdata[1] = bus_b.reg_wdata;
  assign wdata[2] = bus_c.reg_wdata;
  assign bus_a.reg_ready = rdy[0];
  assign bus_b.reg_ready = rdy[1];
  assign bus_c.reg_ready = rdy[2];
  assign bus_a.reg_error = rerr[0];
  assign bus_b.reg_error = rerr[1];
  assign bus_c.reg_error = rerr[2];
  assign bus_a.reg_rdata = rdat[0];
  assign bus_b.reg_rdata = rdat[1];
  assign bus_c.reg_rdata = rdat[2];

  // Slave: register memory plus one injected fault per instance.
  // kind 1 write error, 2/4 read data flip, 3 read error.
  int          fkind [3];
  logic [31:0] faddr [3];
  logic [31:0] flip  [3];
  logic [31:0] mem   [3][16];

  always_comb begin
    rerr = '0;
    for (int k = 0; k < 3; k++) begin
      rdat[k] = mem[k][addr[k][5:2]];
      if (addr[k] == faddr[k]) begin
        if (fkind[k] == 1 && wr[k]) rerr[k] = 1'b1;
        if (fkind[k] == 3 && !wr[k]) rerr[k] = 1'b1;
        if ((fkind[k] == 2 || fkind[k] == 4) && !wr[k])
          rdat[k] = rdat[k] ^ flip[k];
      end
    end
  end

  logic [64:0] lg0 [$];
  logic [64:0] lg1 [$];
  logic [64:0] lg2 [$];

  function automatic logic [64:0] ent(input int k);
    return {wr[k], addr[k], wr[k] ? wdata[k] : 32'h0};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (vld[k] && rdy[k] && wr[k])
        mem[k][addr[k][5:2]] <= wdata[k];
    if (vld[0] && rdy[0]) lg0.push_back(ent(0));
    if (vld[1] && rdy[1]) lg1.push_back(ent(1));
    if (vld[2] && rdy[2]) lg2.push_back(ent(2));
  end

  function automatic int lg_len(input int k);
    if (k == 0) return lg0.size();
    if (k == 1) return lg1.size();
    return lg2.size();
  endfunction

  function automatic logic [64:0] lg_at(input int k, input int i);
    if (k == 0) return lg0[i];
    if (k == 1) return lg1[i];
    return lg2[i];
  endfunction

  task automatic lg_clear(input int k);
    if (k == 0) lg0.delete();
    else if (k == 1) lg1.delete();
    else lg2.delete();
  endtask

  // Reference model: configuration tables and expected transcript.
  function automatic int nent(input int k);
    return (k == 2) ? 1 : 3;
  endfunction
  function automatic bit ver(input int k);
    return k != 0;
  endfunction
  function automatic logic [31:0] caddr(input int k, input int i);
    return (k == 2) ? 32'h10 : 32'(4 * i);
  endfunction
  function automatic logic [31:0] cdata(input int k, input int i);
    return (k == 2) ? 32'hCAFE_0001 : 32'(17 * (i + 1));
  endfunction
  function automatic logic [31:0] vmask(input int k);
    return (k == 1) ? 32'hFF : 32'hFFFF_FFFF;
  endfunction

  logic [64:0] exp_q [$];
  bit          exp_err;
  int          exp_eidx;

  task automatic build_exp(input int k, input int fk,
                           input int fi, input logic [31:0] fl);
    exp_q.delete();
    exp_err  = 1'b0;
    exp_eidx = 0;
    for (int i = 0; i < nent(k); i++) begin
      exp_q.push_back({1'b1, caddr(k, i), cdata(k, i)});
      if (fk == 1 && i == fi) begin
        exp_err = 1'b1; exp_eidx = i; return;
      end
      if (ver(k)) begin
        exp_q.push_back({1'b0, caddr(k, i), 32'h0});
        if (i == fi && (fk == 3 || ((fk == 2 || fk == 4)
            && (fl & vmask(k)) != 0))) begin
          exp_err = 1'b1; exp_eidx = i; return;
        end
      end
    end
  endtask

  task automatic set_fault(input int k, input int fk,
                           input int fi, input logic [31:0] fl);
    fkind[k] = fk;
    faddr[k] = caddr(k, fi);
    flip[k]  = fl;
  endtask

  task automatic run_seq(input int k, output int cyc);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
    cyc = 0;
    while (!done[k] && cyc < 50) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; st = '0; rdy = '1;
    set_fault(0, 0, 0, 0);
    set_fault(1, 2, 1, 32'h1);
    set_fault(2, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({vld[0], wr[0], busy[0], done[0], err[0], gate[0]}
        !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 000000",
        {vld[0], wr[0], busy[0], done[0], err[0], gate[0]});
    end
    checks++;
    if ({addr[0], wdata[0]} !== 64'h0) begin
      errors++;
      $display("FAIL rst_fields got %h want 0",
        {addr[0], wdata[0]});
    end
    checks++;
    if ({bus_a.reg_wstrb, eidx[0]} !== 6'b111100) begin
      errors++;
      $display("FAIL rst_strb_idx got %b want 111100",
        {bus_a.reg_wstrb, eidx[0]});
    end
    checks++;
    if ({vld[2], vld[1]} !== 2'b00) begin
      errors++;
      $display("FAIL rst_valid_bc got %b want 00", vld[2:1]);
    end
  endtask

  task automatic test_autostart;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL auto_first_cycle got %b want 0", vld[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({vld[0], wr[0], busy[0], done[0], addr[0], wdata[0]}
          !== {4'b1110, caddr(0, i), cdata(0, i)}) begin
        errors++;
        $display("FAIL auto_write%0d got %h want %h", i,
          {vld[0], wr[0], busy[0], done[0], addr[0], wdata[0]},
          {4'b1110, caddr(0, i), cdata(0, i)});
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({vld[0], busy[0], done[0], err[0], gate[0]}
        !== 5'b00101) begin
      errors++;
      $display("FAIL auto_done got %b want 00101",
        {vld[0], busy[0], done[0], err[0], gate[0]});
    end
    checks++;
    if ({vld[2], done[2], busy[2]} !== 3'b000) begin
      errors++;
      $display("FAIL no_autostart got %b want 000",
        {vld[2], done[2], busy[2]});
    end
  endtask

  task automatic test_verify_mismatch;
    repeat (2) @(negedge clk);
    build_exp(1, 2, 1, 32'h1);
    checks++;
    if (lg_len(1) !== exp_q.size()) begin
      errors++;
      $display("FAIL vmis_len got %0d want %0d",
        lg_len(1), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (lg_at(1, i) !== exp_q[i]) begin
          errors++;
          $display("FAIL vmis_txn%0d got %h want %h",
            i, lg_at(1, i), exp_q[i]);
        end
      end
    end
    checks++;
    if ({vld[1], done[1], err[1], gate[1], eidx[1]}
        !== 6'b011001) begin
      errors++;
      $display("FAIL vmis_flags got %b want 011001",
        {vld[1], done[1], err[1], gate[1], eidx[1]});
    end
  endtask

  task automatic test_back_pressure;
    int cyc, held, stall;
    lg_clear(0);
    held = 0; stall = 0;
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    cyc = 0;
    while (!done[0] && cyc < 40) begin
      rdy[0] = 1'b1;
      if (vld[0] && addr[0] == 32'h4) begin
        held++;
        checks++;
        if (wdata[0] !== 32'h22) begin
          errors++;
          $display("FAIL bp_hold_data got %h want 22", wdata[0]);
        end
        if (stall < 5) begin
          rdy[0] = 1'b0; stall++;
        end
      end
      @(negedge clk); cyc++;
    end
    rdy[0] = 1'b1;
    checks++;
    if (held !== 6) begin
      errors++;
      $display("FAIL bp_held got %0d want 6", held);
    end
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL bp_latency got %0d want 8", cyc);
    end
    build_exp(0, 0, 0, 0);
    checks++;
    if (lg_len(0) !== 3 || lg_at(0, 1) !== exp_q[1]
        || lg_at(0, 2) !== exp_q[2]) begin
      errors++;
      $display("FAIL bp_order got %0d entries want 3", lg_len(0));
    end
  endtask

  task automatic test_write_error;
    int cyc;
    lg_clear(0);
    set_fault(0, 1, 0, 0);
    run_seq(0, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL werr_latency got %0d want 1", cyc);
    end
    checks++;
    if ({done[0], err[0], gate[0], eidx[0], lg_len(0) == 1}
        !== 6'b110001) begin
      errors++;
      $display("FAIL werr_flags got %b want 110001",
        {done[0], err[0], gate[0], eidx[0], lg_len(0) == 1});
    end
  endtask

  task automatic test_restart_ignore;
    lg_clear(0);
    set_fault(0, 0, 0, 0);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    checks++;
    if ({done[0], err[0], gate[0], eidx[0], vld[0], wr[0],
         busy[0], addr[0]} !== {9'b000000111, 32'h0}) begin
      errors++;
      $display("FAIL restart_clear got %h want %h",
        {done[0], err[0], gate[0], eidx[0], vld[0], wr[0],
         busy[0], addr[0]}, {9'b000000111, 32'h0});
    end
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    checks++;
    if ({vld[0], addr[0]} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL midseq_start_ignored got %h want 100000008",
        {vld[0], addr[0]});
    end
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld[0], done[0], gate[0], lg_len(0) == 3} !== 4'b0111)
    begin
      errors++;
      $display("FAIL last_hs_start_ignored got %b want 0111",
        {vld[0], done[0], gate[0], lg_len(0) == 3});
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    lg_clear(0);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if ({vld[0], busy[0], gate[0], done[0], addr[0]}
        !== 36'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0",
        {vld[0], busy[0], gate[0], done[0], addr[0]});
    end
    @(negedge clk); rst_n = 1'b1;
    lg_clear(0);
    @(posedge clk); #1;
    checks++;
    if (vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wait got %b want 0", vld[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({vld[0], addr[0]} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_rerun got %h want 100000000",
        {vld[0], addr[0]});
    end
    cyc = 0;
    while (!done[0] && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    build_exp(0, 0, 0, 0);
    checks++;
    if (lg_len(0) !== 3 || lg_at(0, 0) !== exp_q[0]
        || gate[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_complete got %0d entries gate %b want 3 1",
        lg_len(0), gate[0]);
    end
  endtask

  task automatic test_single_entry;
    int cyc;
    for (int f = 0; f < 2; f++) begin
      lg_clear(2);
      set_fault(2, f * 3, 0, 0);
      build_exp(2, f * 3, 0, 0);
      run_seq(2, cyc);
      checks++;
      if (cyc !== 2) begin
        errors++;
        $display("FAIL single%0d_latency got %0d want 2", f, cyc);
      end
      checks++;
      if (lg_len(2) !== 2 || lg_at(2, 0) !== exp_q[0]
          || lg_at(2, 1) !== exp_q[1]) begin
        errors++;
        $display("FAIL single%0d_txns got %0d want 2",
          f, lg_len(2));
      end
      checks++;
      if ({done[2], err[2], gate[2], eidx[2]}
          !== {1'b1, exp_err, !exp_err, 2'b00}) begin
        errors++;
        $display("FAIL single%0d_flags got %b want %b", f,
          {done[2], err[2], gate[2], eidx[2]},
          {1'b1, exp_err, !exp_err, 2'b00});
      end
    end
  endtask

  task automatic test_random;
    int k, fk, fi, cyc;
    logic [31:0] fl;
    logic [65:0] pf;
    bit pend;
    for (int it = 0; it < 40; it++) begin
      k  = $urandom_range(0, 2);
      fk = $urandom_range(0, 4);
      fi = $urandom_range(0, nent(k) - 1);
      fl = (fk == 4) ? (32'h1 << $urandom_range(8, 31))
                     : (32'h1 << $urandom_range(0, 7));
      set_fault(k, fk, fi, fl);
      build_exp(k, fk, fi, fl);
      lg_clear(k);
      pend = 1'b0;
      @(negedge clk); st[k] = 1'b1;
      @(negedge clk); st[k] = 1'b0;
      cyc = 0;
      while (!done[k] && cyc < 200) begin
        if (pend) begin
          checks++;
          if ({vld[k], wr[k], addr[k], wdata[k]} !== pf) begin
            errors++;
            $display("FAIL rnd%0d_stall_hold got %h want %h", it,
              {vld[k], wr[k], addr[k], wdata[k]}, pf);
          end
        end
        rdy[k] = ($urandom_range(0, 3) != 0);
        pend = vld[k] && !rdy[k];
        pf = {vld[k], wr[k], addr[k], wdata[k]};
        @(negedge clk); cyc++;
      end
      rdy[k] = 1'b1;
      checks++;
      if (lg_len(k) !== exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_len got %0d want %0d",
          it, lg_len(k), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (lg_at(k, i) !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd%0d_txn%0d got %h want %h",
              it, i, lg_at(k, i), exp_q[i]);
          end
        end
      end
      checks++;
      if ({done[k], busy[k], err[k], gate[k], eidx[k]}
          !== {2'b10, exp_err, !exp_err, 2'(exp_eidx)}) begin
        errors++;
        $display("FAIL rnd%0d_flags got %b want %b", it,
          {done[k], busy[k], err[k], gate[k], eidx[k]},
          {2'b10, exp_err, !exp_err, 2'(exp_eidx)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_autostart();
    test_verify_mismatch();
    test_back_pressure();
    test_write_error();
    test_restart_ignore();
    test_reset_mid();
    test_single_entry();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
